alu_param: RTL and testbench

- Parametrised successor to the ucontroller 8-bit ALU.
- Data width is generic. Adds shifts, compare, and an explicit valid/busy operation handshake.
- Adds an optional iterative (multi-cycle) shift-add multiplier.
- Sits between the ucontroller decode stage and the data bus. Holds operand registers A and B, an accumulator ACC and four flags.

---
 rtl/alu_param.sv | 183 ++++++++++++++++++
 tb/tb_alu_param.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_param.sv
// Parametrised ALU with operand registers A/B, an accumulator and Z/C/N/E flags, using a valid/busy handshake.
// Defining ALU_PARAM_MUL_EN adds the iterative shift-add multiplier (op 11) and its Busy handshake.
module alu_param #(
    parameter int WIDTH     = 8,
    parameter int MUL_CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Op_valid,
    input  logic [3:0]       Op_code,
    input  logic [WIDTH-1:0] InData,
    output logic             Busy,
    output logic [WIDTH-1:0] OutData,
    output logic             Out_valid,
    output logic             FlagZ,
    output logic             FlagC,
    output logic             FlagN,
    output logic             FlagE
);

    typedef enum logic [3:0] {
        OP_NOP, OP_LDA, OP_LDB, OP_ADD, OP_SUB, OP_AND, OP_OR,
        OP_XOR, OP_SHL, OP_SHR, OP_CMP, OP_MUL, OP_OEACC
    } op_e;

    if (WIDTH < 4 || WIDTH > 32 || MUL_CNT_W != $clog2(WIDTH + 1)) begin : g_bad_param
        $error("alu_param: WIDTH must be 4..32 and MUL_CNT_W must not be overridden");
    end

    logic [WIDTH-1:0] a_reg, b_reg, acc;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_e, acc_we, flag_we, neg_b_msb;
    logic             accept;
    logic             mul_done, mul_c;
    logic [WIDTH-1:0] mul_res;

    assign accept = Op_valid && !Busy;

    // MSB of (~B + 1): the increment only carries into the MSB when all lower bits of B are zero.
    assign neg_b_msb = ~b_reg[WIDTH-1] ^ (b_reg[WIDTH-2:0] == '0);

    // NOTE: every variable gets a default before the case so that no path leaves one unassigned (no latches).
    always_comb begin
        sum     = '0;
        alu_res = acc;
        alu_c   = 1'b0;
        alu_e   = 1'b0;
        acc_we  = 1'b0;
        flag_we = 1'b0;
        case (Op_code)
            OP_ADD: begin
                sum     = {1'b0, a_reg} + {1'b0, b_reg};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_e   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (alu_res[WIDTH-1] != a_reg[WIDTH-1]);
                acc_we  = 1'b1;
                flag_we = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                sum     = {1'b0, a_reg} - {1'b0, b_reg};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_e   = (a_reg[WIDTH-1] == neg_b_msb) && (alu_res[WIDTH-1] != a_reg[WIDTH-1]);
                acc_we  = (Op_code == OP_SUB);
                flag_we = 1'b1;
            end
            OP_AND: begin alu_res = a_reg & b_reg; acc_we = 1'b1; flag_we = 1'b1; end
            OP_OR:  begin alu_res = a_reg | b_reg; acc_we = 1'b1; flag_we = 1'b1; end
            OP_XOR: begin alu_res = a_reg ^ b_reg; acc_we = 1'b1; flag_we = 1'b1; end
            OP_SHL: begin
                alu_res = {a_reg[WIDTH-2:0], 1'b0};
                alu_c   = a_reg[WIDTH-1];
                acc_we  = 1'b1;
                flag_we = 1'b1;
            end
            OP_SHR: begin
                alu_res = {1'b0, a_reg[WIDTH-1:1]};
                alu_c   = a_reg[0];
                acc_we  = 1'b1;
                flag_we = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            OutData   <= '0;
            Out_valid <= 1'b0;
            FlagZ     <= 1'b0;
            FlagC     <= 1'b0;
            FlagN     <= 1'b0;
            FlagE     <= 1'b0;
        end else begin
            Out_valid <= 1'b0;
            OutData   <= '0;
            if (mul_done) begin
                acc   <= mul_res;
                FlagZ <= (mul_res == '0);
                FlagC <= mul_c;
                FlagN <= mul_res[WIDTH-1];
                FlagE <= 1'b0;
            end else if (accept) begin
                if (Op_code == OP_LDA) a_reg <= InData;
                if (Op_code == OP_LDB) b_reg <= InData;
                if (Op_code == OP_OEACC) begin
                    Out_valid <= 1'b1;
                    OutData   <= acc;
                end
                if (acc_we) acc <= alu_res;
                if (flag_we) begin
                    FlagZ <= (alu_res == '0);
                    FlagC <= alu_c;
                    FlagN <= alu_res[WIDTH-1];
                    FlagE <= alu_e;
                end
            end
        end
    end

`ifdef ALU_PARAM_MUL_EN
    typedef enum logic [1:0] {M_IDLE, M_RUN, M_DONE} mul_state_e;

    mul_state_e           mul_state, mul_state_nxt;
    logic [2*WIDTH-1:0]   mcand, product;
    logic [WIDTH-1:0]     mplier;
    logic [MUL_CNT_W-1:0] mul_cnt;
    logic                 mul_start;

    assign mul_start = accept && (Op_code == OP_MUL);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) mul_state <= M_IDLE;
        else        mul_state <= mul_state_nxt;
    end

    always_comb begin
        mul_state_nxt = mul_state;
        case (mul_state)
            M_IDLE: if (mul_start) mul_state_nxt = M_RUN;
            M_RUN:  if (mul_cnt == MUL_CNT_W'(WIDTH - 1)) mul_state_nxt = M_DONE;
            M_DONE: mul_state_nxt = M_IDLE;
            default: mul_state_nxt = M_IDLE;
        endcase
    end

    // One shift-add step per RUN cycle: add the shifted multiplicand when the current multiplier bit is set.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
            mul_cnt <= '0;
        end else if (mul_start) begin
            mcand   <= {{WIDTH{1'b0}}, a_reg};
            mplier  <= b_reg;
            product <= '0;
            mul_cnt <= '0;
        end else if (mul_state == M_RUN) begin
            if (mplier[0]) product <= product + mcand;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            mul_cnt <= mul_cnt + MUL_CNT_W'(1);
        end
    end

    assign Busy     = (mul_state != M_IDLE);
    assign mul_done = (mul_state == M_DONE);
    assign mul_res  = product[WIDTH-1:0];
    assign mul_c    = |product[2*WIDTH-1:WIDTH];
`else
    assign Busy     = 1'b0;
    assign mul_done = 1'b0;
    assign mul_res  = '0;
    assign mul_c    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_param.sv
// Directed bench for alu_param: an 8-bit and a 16-bit instance share one op bus.
// MUL checks run when ALU_PARAM_MUL_EN is defined; otherwise op 11 is checked as a NOP.
module tb_alu_param;

    localparam logic [3:0] NOP = 4'd0, LDA = 4'd1, LDB = 4'd2, ADD = 4'd3, SUB = 4'd4,
                           AND_ = 4'd5, OR_ = 4'd6, XOR_ = 4'd7, SHL = 4'd8, SHR = 4'd9,
                           CMP = 4'd10, MUL = 4'd11, OEACC = 4'd12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic [3:0]  op_code;
    logic [15:0] in_data;

    logic        busy8, ov8, z8, c8, n8, e8;
    logic [7:0]  od8;
    logic        busy16, ov16, z16, c16, n16, e16;
    logic [15:0] od16;

    int compared   = 0;
    int mismatched = 0;
    int cnt8, cnt16;

    always #5 clk = ~clk;

    alu_param #(.WIDTH(8)) u8 (
        .Clk(clk), .Rst_n(rst_n), .Op_valid(op_valid), .Op_code(op_code), .InData(in_data[7:0]),
        .Busy(busy8), .OutData(od8), .Out_valid(ov8),
        .FlagZ(z8), .FlagC(c8), .FlagN(n8), .FlagE(e8)
    );

    alu_param #(.WIDTH(16)) u16 (
        .Clk(clk), .Rst_n(rst_n), .Op_valid(op_valid), .Op_code(op_code), .InData(in_data),
        .Busy(busy16), .OutData(od16), .Out_valid(ov16),
        .FlagZ(z16), .FlagC(c16), .FlagN(n16), .FlagE(e16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flags packed as {Z,C,N,E}.
    function automatic logic [3:0] f8();
        return {z8, c8, n8, e8};
    endfunction

    function automatic logic [3:0] f16();
        return {z16, c16, n16, e16};
    endfunction

    // Presents one op for a single rising edge; returns 1 time unit after that edge.
    task automatic step(input logic [3:0] op, input logic [15:0] d);
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = op;
        in_data  = d;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op_code  = NOP;
    endtask

    // Counts the sampled Busy cycles of each instance until both are idle, with a cycle bound.
    task automatic wait_idle(output int n8_out, output int n16_out);
        n8_out  = 0;
        n16_out = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy8 && !busy16) break;
            if (busy8) n8_out++;
            if (busy16) n16_out++;
            @(posedge clk);
            #1;
        end
        check("busy_timeout", {busy8, busy16}, 2'b00);
    endtask

    initial begin
        rst_n    = 1'b0;
        op_valid = 1'b0;
        op_code  = NOP;
        in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctrl8", {busy8, ov8, od8}, 10'h0);
        check("rst_flags8", f8(), 4'b0000);
        check("rst_ctrl16", {busy16, ov16, od16}, 18'h0);
        check("rst_flags16", f16(), 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        // 0xFF + 0x02 with carry out, then a single-cycle OEACC pulse
        step(LDA, 16'h00FF);
        step(LDB, 16'h0002);
        step(ADD, 16'h0);
        check("add_ff_02_flags8", f8(), 4'b0100);
        check("add_ff_02_flags16", f16(), 4'b0000);
        step(OEACC, 16'h0);
        check("oe_add_valid8", ov8, 1'b1);
        check("oe_add_data8", od8, 8'h01);
        check("oe_add_data16", od16, 16'h0101);
        @(posedge clk);
        #1;
        check("oe_drop8", {ov8, od8}, 9'h0);

        // signed overflow, borrow, compare-equal
        step(LDA, 16'h007F);
        check("lda_keeps_flags8", f8(), 4'b0100);
        step(LDB, 16'h0001);
        step(ADD, 16'h0);
        check("add_ovf_flags8", f8(), 4'b0011);
        step(OEACC, 16'h0);
        check("add_ovf_data8", od8, 8'h80);
        step(LDA, 16'h0005);
        step(LDB, 16'h0006);
        step(SUB, 16'h0);
        check("sub_borrow_flags8", f8(), 4'b0110);
        step(LDA, 16'h0010);
        step(LDB, 16'h0010);
        step(CMP, 16'h0);
        check("cmp_eq_flags8", f8(), 4'b1000);
        step(OEACC, 16'h0);
        check("cmp_keeps_acc8", od8, 8'hFF);

        // shifts and logic ops
        step(LDA, 16'h0081);
        step(SHL, 16'h0);
        check("shl_flags8", f8(), 4'b0100);
        step(OEACC, 16'h0);
        check("shl_data8", od8, 8'h02);
        step(SHR, 16'h0);
        check("shr_flags8", f8(), 4'b0100);
        step(OEACC, 16'h0);
        check("shr_data8", od8, 8'h40);
        step(LDA, 16'h00F0);
        step(LDB, 16'h000F);
        step(XOR_, 16'h0);
        check("xor_flags8", f8(), 4'b0010);
        step(OEACC, 16'h0);
        check("xor_data8", od8, 8'hFF);
        step(LDA, 16'h0077);
        step(LDB, 16'h00CC);
        step(OR_, 16'h0);
        step(OEACC, 16'h0);
        check("or_data8", od8, 8'hFF);
        step(LDA, 16'h00FF);
        step(LDB, 16'h0088);
        step(AND_, 16'h0);
        check("and_flags8", f8(), 4'b0010);
        step(OEACC, 16'h0);
        check("and_data8", od8, 8'h88);
        step(OEACC, 16'h0);
        check("oe_b2b8", {ov8, od8}, 9'h188);
        @(posedge clk);
        #1;
        check("oe_b2b_drop8", ov8, 1'b0);

        // illegal op is a NOP
        step(4'd13, 16'h0);
        check("illegal_flags8", f8(), 4'b0010);
        step(OEACC, 16'h0);
        check("illegal_acc8", od8, 8'h88);

        // 16-bit wrap to zero and borrow
        step(LDA, 16'hFFFF);
        step(LDB, 16'h0001);
        step(ADD, 16'h0);
        check("add16_wrap_flags", f16(), 4'b1100);
        step(OEACC, 16'h0);
        check("add16_wrap_data", od16, 16'h0000);
        step(LDA, 16'h0000);
        step(SUB, 16'h0);
        check("sub16_borrow_flags", f16(), 4'b0110);
        step(OEACC, 16'h0);
        check("sub16_borrow_data", od16, 16'hFFFF);
        check("sub8_borrow_data", od8, 8'hFF);

`ifdef ALU_PARAM_MUL_EN
        // 0x0F * 0x11 = 0xFF, Busy WIDTH+1 cycles
        step(LDA, 16'h000F);
        step(LDB, 16'h0011);
        step(MUL, 16'h0);
        wait_idle(cnt8, cnt16);
        check("mul_busy8", cnt8, 9);
        check("mul_busy16", cnt16, 17);
        check("mul_0f_11_flags8", f8(), 4'b0010);
        check("mul_0f_11_flags16", f16(), 4'b0000);
        step(OEACC, 16'h0);
        check("mul_0f_11_data8", od8, 8'hFF);
        check("mul_0f_11_data16", od16, 16'h00FF);
        step(ADD, 16'h0);
        step(OEACC, 16'h0);
        check("mul_keeps_ab8", od8, 8'h20);

        // 0x10 * 0x10 overflows to zero; an ADD strobed while Busy is dropped
        step(LDA, 16'h0010);
        step(LDB, 16'h0010);
        step(MUL, 16'h0);
        step(ADD, 16'h0);
        wait_idle(cnt8, cnt16);
        check("mul_ovf_flags8", f8(), 4'b1100);
        step(OEACC, 16'h0);
        check("mul_ovf_data8", od8, 8'h00);

        // 16-bit 0x0100 * 0x0100
        step(LDA, 16'h0100);
        step(LDB, 16'h0100);
        step(MUL, 16'h0);
        wait_idle(cnt8, cnt16);
        check("mul16_busy", cnt16, 17);
        check("mul16_flags", f16(), 4'b1100);
        step(OEACC, 16'h0);
        check("mul16_data", od16, 16'h0000);

        // reset during the 4th RUN cycle
        step(LDA, 16'h00FF);
        step(LDB, 16'h0002);
        step(ADD, 16'h0);
        step(MUL, 16'h0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mul_rst_async", {busy8, busy16, f8(), f16()}, 10'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(OEACC, 16'h0);
        check("mul_rst_acc", {od8, od16}, 24'h0);
        step(LDA, 16'h0003);
        step(LDB, 16'h0005);
        step(MUL, 16'h0);
        wait_idle(cnt8, cnt16);
        step(OEACC, 16'h0);
        check("mul_3_5_data8", od8, 8'h0F);
        check("mul_3_5_data16", od16, 16'h000F);
`else
        // without the multiplier, op 11 is a NOP and Busy never rises
        step(MUL, 16'h0);
        check("op11_busy", {busy8, busy16}, 2'b00);
        check("op11_flags16", f16(), 4'b0110);
        step(NOP, 16'h0);
        check("op11_busy_later", {busy8, busy16}, 2'b00);
        step(OEACC, 16'h0);
        check("op11_acc16", od16, 16'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
